imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory from a byte stream. It accepts a length-prefixed, MSB-first byte stream over a valid/ready handshake, assembles 32-bit instruction words, and issues one write per word to sequential word-aligned byte addresses. While loading, it holds the processor in reset. When loading finishes, it releases the hold so the core fetches the freshly written program.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader_word_assembler.sv | 31 +++
 rtl/imem_loader.sv | 110 +++++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the boot-time instruction memory loader: state encoding,
// stream framing sizes and byte-lane geometry.
package imem_loader_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEN_HI = 3'd1;
   localparam logic [2:0] ST_LEN_LO = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_WRITE  = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   localparam logic [2:0] ST_ERROR  = 3'd6;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

   // Bytes arrive MSB first, so each new byte enters at the low lane and the
   // first byte of a word ends up in bits [31:24].
   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned WORD_W        = 32;
   localparam logic [1:0]  LAST_BYTE_IDX = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus the instruction-memory write port of the loader.
interface imem_loader_if;

   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport slave (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output wr_en,
      output wr_addr,
      output wr_data
   );

   modport master (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data
   );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs four MSB-first stream bytes into one 32-bit instruction word.
module imem_loader_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        shift_en,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_complete
);

   logic [1:0] idx;

   assign word_complete = shift_en && (idx == LAST_BYTE_IDX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word <= '0;
         idx  <= '0;
      end else if (clear) begin
         word <= '0;
         idx  <= '0;
      end else if (shift_en) begin
         word <= {word[WORD_W-BYTE_W-1:0], byte_in};
         idx  <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a length-prefixed byte stream, writes one instruction word per
// four bytes to sequential addresses, and holds the core in reset while loading.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   imem_loader_if.slave bus,
   output logic         cpu_hold,
   output logic         busy,
   output logic         done,
   output logic         error
);

   logic [2:0]  state;
   logic [2:0]  state_next;
   logic [15:0] count;
   logic [15:0] word_cnt;
   logic [15:0] word_cnt_inc;
   logic [31:0] addr;
   logic [31:0] hdr_words;
   logic [31:0] word;
   logic        xfer;
   logic        shift_en;
   logic        at_rest;
   logic        accept_start;
   logic        word_complete;

   // All handshake and status outputs decode from state alone.
   assign bus.byte_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA);
   assign bus.wr_en      = (state == ST_WRITE);
   assign bus.wr_addr    = addr;
   assign bus.wr_data    = word;

   assign busy     = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                     (state == ST_DATA)   || (state == ST_WRITE);
   assign cpu_hold = busy;
   assign done     = (state == ST_DONE);
   assign error    = (state == ST_ERROR);

   assign xfer         = bus.byte_valid && bus.byte_ready;
   assign shift_en     = xfer && (state == ST_DATA);
   assign at_rest      = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
   assign accept_start = start && at_rest;
   assign hdr_words    = {16'd0, count[15:8], bus.byte_data};
   assign word_cnt_inc = word_cnt + 16'd1;

   imem_loader_word_assembler u_asm (
      .clk           (clk),
      .reset         (reset),
      .shift_en      (shift_en),
      .clear         (accept_start),
      .byte_in       (bus.byte_data),
      .word          (word),
      .word_complete (word_complete)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) state_next = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (xfer) state_next = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (xfer) begin
               if (hdr_words == 32'd0)          state_next = ST_DONE;
               else if (hdr_words > MEM_WORDS)  state_next = ST_ERROR;
               else                             state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (word_complete) state_next = ST_WRITE;
         end
         ST_WRITE: begin
            state_next = (word_cnt_inc == count) ? ST_DONE : ST_DATA;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         count    <= '0;
         word_cnt <= '0;
         addr     <= BASE_ADDR;
      end else begin
         state <= state_next;
         if (accept_start) begin
            word_cnt <= '0;
            addr     <= BASE_ADDR;
         end
         if (xfer && (state == ST_LEN_HI)) count[15:8] <= bus.byte_data;
         if (xfer && (state == ST_LEN_LO)) count[7:0]  <= bus.byte_data;
         // Address moves only after the write cycle so it is stable while wr_en is high.
         if (state == ST_WRITE) begin
            word_cnt <= word_cnt_inc;
            addr     <= addr + 32'(BYTES_PER_WORD);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances at different base addresses
// share one byte stream; writes are scored against a word-list model.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int unsigned MEM_WORDS = 1024;
   localparam logic [31:0] BASE0     = 32'h0000_0000;
   localparam logic [31:0] BASE1     = 32'h0000_0100;

   typedef struct {
      logic [15:0] hdr;
      bit          rv;
      bit          poke;
      bit          fixed;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       bv    = 1'b0;
   logic [7:0] bd    = 8'h00;
   logic       hold0, busy0, done0, err0;
   logic       hold1, busy1, done1, err1;

   imem_loader_if bus0 ();
   imem_loader_if bus1 ();

   assign bus0.byte_valid = bv;
   assign bus0.byte_data  = bd;
   assign bus1.byte_valid = bv;
   assign bus1.byte_data  = bd;

   imem_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE0)) dut0 (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (bus0),
      .cpu_hold (hold0),
      .busy     (busy0),
      .done     (done0),
      .error    (err0)
   );

   imem_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE1)) dut1 (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (bus1),
      .cpu_hold (hold1),
      .busy     (busy1),
      .done     (done1),
      .error    (err1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] got0[$];
   logic [63:0] got1[$];
   always @(negedge clk) begin
      if (bus0.wr_en) got0.push_back({bus0.wr_addr, bus0.wr_data});
      if (bus1.wr_en) got1.push_back({bus1.wr_addr, bus1.wr_data});
   end

   int          passed = 0;
   int          total  = 0;
   int          t0     = 0;
   logic [31:0] words[$];
   logic [7:0]  stream[$];
   logic [31:0] fixed_w[3] = '{32'h2008_0005, 32'h2009_000A, 32'h0109_5020};

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, got, exp);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ctl"}, 64'({bus0.byte_ready, bus0.wr_en, hold0, busy0, done0, err0,
                                bus1.byte_ready, bus1.wr_en, hold1, busy1, done1, err1}), 64'd0);
      check({tag, "_bus0"}, {bus0.wr_addr, bus0.wr_data}, {BASE0, 32'd0});
      check({tag, "_bus1"}, {bus1.wr_addr, bus1.wr_data}, {BASE1, 32'd0});
   endtask

   task automatic build_stream(input logic [15:0] hdr);
      stream.delete();
      stream.push_back(hdr[15:8]);
      stream.push_back(hdr[7:0]);
      foreach (words[k])
         for (int j = 0; j < 4; j++) stream.push_back(8'((words[k] >> (24 - 8 * j)) & 32'hFF));
   endtask

   task automatic begin_session();
      got0.delete();
      got1.delete();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   // Offers stream bytes until `limit` of them have been accepted.
   task automatic send(input int limit, input bit rv, input bit poke);
      int   idx;
      int   guard;
      logic rdy;
      bit   first;
      idx   = 0;
      guard = 0;
      first = 1'b1;
      while (idx < limit && guard < 50000) begin
         bv    = rv ? 1'($urandom_range(0, 1)) : 1'b1;
         bd    = stream[idx];
         start = poke && (idx >= 8) && (idx < 12);
         @(negedge clk);
         if (first) begin
            check("session_entry", 64'({hold0, busy0, done0, err0, hold1, busy1, done1, err1}),
                  64'h00CC);
            first = 1'b0;
         end
         rdy = bus0.byte_ready;
         @(posedge clk);
         #1;
         if (bv && rdy) idx++;
         guard++;
      end
      bv    = 1'b0;
      bd    = 8'h00;
      start = 1'b0;
      check("bytes_consumed", 64'(idx), 64'(limit));
   endtask

   task automatic finish_session(input logic [15:0] hdr, input bit rv, input bit exp_done,
                                 input bit exp_err);
      int guard;
      int n;
      n     = (32'(hdr) > MEM_WORDS) ? 0 : int'(hdr);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(done0 || err0) && guard < 64);
      if (!rv)
         check("latency", 64'(cyc - t0),
               64'(exp_err ? HDR_BYTES : HDR_BYTES + (BYTES_PER_WORD + 1) * n));
      check("status0", 64'({done0, err0}), 64'({exp_done, exp_err}));
      check("status1", 64'({done1, err1}), 64'({exp_done, exp_err}));
      check("rest_outputs", 64'({hold0, busy0, bus0.byte_ready, hold1, busy1, bus1.byte_ready}),
            64'd0);
      check("write_count0", 64'(got0.size()), 64'(n));
      check("write_count1", 64'(got1.size()), 64'(n));
      for (int k = 0; k < n; k++) begin
         if (k < got0.size()) check("write0", got0[k], {BASE0 + 32'(4 * k), words[k]});
         if (k < got1.size()) check("write1", got1[k], {BASE1 + 32'(4 * k), words[k]});
      end
      // Bytes offered after the session must be refused and status must hold.
      bv = 1'b1;
      bd = 8'hA5;
      repeat (3) @(negedge clk);
      check("held_after", 64'({done0, err0, bus0.byte_ready}), 64'({exp_done, exp_err, 1'b0}));
      check("no_extra_writes", 64'(got0.size() + got1.size()), 64'(2 * n));
      bv = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      n = (32'(v.hdr) > MEM_WORDS) ? 0 : int'(v.hdr);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back(v.fixed ? fixed_w[k % 3] : $urandom());
      build_stream(v.hdr);
      begin_session();
      send(stream.size(), v.rv, v.poke);
      finish_session(v.hdr, v.rv, v.exp_done, v.exp_err);
   endtask

   initial begin
      vec_t vecs[9];
      vec_t rnd;
      vecs[0] = '{16'd3,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{16'd3,      1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{16'd0,      1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{16'h0401,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{16'd3,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{16'd2,      1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{16'd5,      1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{16'd1024,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{16'hFFFF,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      check_reset("por");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Reset after two bytes of the second word of an N=2 load.
      words.delete();
      words.push_back($urandom());
      words.push_back($urandom());
      build_stream(16'd2);
      begin_session();
      send(8, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check_reset("async");
      check("partial_count", 64'(got0.size()), 64'd1);
      if (got0.size() > 0) check("partial_word0", got0[0], {BASE0, words[0]});
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rnd = '{16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      run_vec(rnd);

      for (int r = 0; r < 4; r++) begin
         rnd = '{16'($urandom_range(1, 6)), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
         run_vec(rnd);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
